layer_controller: RTL
=====================

Name: layer_controller

Overview:
Sequences one fully-connected layer of sigmoid neurons. On start, it streams the layer's input activations from a registered input buffer. Each activation is broadcast to all neurons as one contiguous, gap-free burst. The controller then waits for the neurons' common output-valid pulse, captures every neuron output, and drains them in order over a valid/ready stream to the next layer or to the max-finder.

Parameters:
numInputs, 784, activations per inference; equals the neurons' weightSize
numNeurons, 30, neurons in the layer
dataWidth, 16, activation/output word width
addrWidth, $clog2(numInputs), input buffer address width
idxWidth, $clog2(numNeurons) (min 1), output index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle request to process one input vector
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last output word is accepted
err  out  1  sticky; neuron valids were not simultaneous; cleared by next accepted start
in_ren  out  1  input buffer read enable
in_raddr  out  addrWidth  input buffer read address
in_rdata  in  dataWidth  input buffer data, valid the cycle after in_ren
nrn_in_valid  out  1  broadcast activation valid to all neurons
nrn_in  out  dataWidth  broadcast activation
nrn_out_valid  in  numNeurons  per-neuron output valid
nrn_out  in  numNeurons*dataWidth  neuron k output at bits [k*dataWidth +: dataWidth]
out_valid  out  1  output word valid
out_ready  in  1  downstream ready
out_data  out  dataWidth  output word
out_idx  out  idxWidth  neuron index of out_data
out_last  out  1  high with the word for neuron numNeurons-1

Behaviour:
- All outputs are registered.
- Synchronous reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - Every output goes to 0.
  - The capture array is not reset.
  - Reset mid-operation abandons the layer: no done, no partial drain.
- States: IDLE, FEED, WAIT, DRAIN.
- IDLE:
  - An edge with start=1 enters FEED, sets busy=1, in_ren=1, in_raddr=0, and clears err.
  - start is ignored in every state other than IDLE.
- FEED:
  - in_ren stays high; in_raddr increments by 1 per cycle.
  - At the edge where in_ren=1 and in_raddr=numInputs-1: in_ren<=0, in_raddr<=0, state<=WAIT.
  - Exactly numInputs consecutive read cycles, with no gaps.
- Broadcast pipeline:
  - ren_d1<=in_ren.
  - nrn_in_valid<=ren_d1 and nrn_in<=in_rdata on every cycle.
  - Word i of the buffer appears on nrn_in two cycles after the cycle in which in_raddr=i.
  - nrn_in_valid is high for exactly numInputs contiguous cycles.
  - nrn_in holds the last captured value when nrn_in_valid is low.
- WAIT:
  - Triggered on the first cycle in which any bit of nrn_out_valid is 1.
  - On that cycle, capture all numNeurons words of nrn_out.
  - If nrn_out_valid is not all-ones on that cycle, set err=1 and still capture.
  - State goes to DRAIN with out_valid=1, out_idx=0, and out_data=captured word 0.
  - out_last=1 if numNeurons=1.
  - There is no timeout; WAIT holds until a valid arrives.
- DRAIN:
  - A transfer occurs on an edge with out_valid and out_ready both high.
  - out_data, out_idx and out_last are stable while out_valid=1 and out_ready=0.
  - After a transfer with out_last=0, the next index is presented on the following cycle, so back-to-back transfers are allowed.
  - After the transfer with out_last=1: out_valid<=0, done<=1 for one cycle, busy<=0, state<=IDLE.
  - A start on the done cycle is accepted: state is IDLE on that cycle.
- Any nrn_out_valid arriving outside WAIT is ignored.
- Minimum layer latency, start to first out_valid: numInputs + neuron pipeline latency + 1 cycles.

Test Plan:
1. Config numInputs=4, numNeurons=3, dataWidth=16. Load buffer {1,2,3,4}; pulse start.
   -> in_raddr reads 0,1,2,3 on consecutive cycles.
   -> nrn_in_valid is high for exactly 4 cycles carrying 1,2,3,4, the first two cycles after in_raddr=0.
2. Neuron model asserts nrn_out_valid=3'b111 with words {0x0100,0x0200,0x0300}, out_ready=1.
   -> Three consecutive beats idx 0,1,2 with those values.
   -> out_last on idx 2 only.
   -> done pulse on the next cycle; busy drops.
3. Same stimulus, with out_ready toggling 0,1,0,0,1,1.
   -> Data and idx hold while stalled.
   -> Exactly 3 transfers, in order; no duplicates.
4. nrn_out_valid=3'b101 in WAIT.
   -> err=1; all 3 words still drained.
   -> err cleared at the next accepted start.
5. Pulse start during FEED and during DRAIN.
   -> Ignored: the address sequence and output beats are unchanged.
6. Assert rst_n=0 at read 2 of FEED, then release and start again.
   -> All outputs are 0 during reset; no done.
   -> The fresh run restarts at address 0 and completes normally.

Source files
------------

// File: rtl/layer_controller.sv
// rtl/layer_controller.sv - sequencer for one fully-connected layer: feed, wait, capture, drain
module layer_controller #(
    parameter int num_inputs  = 784,
    parameter int num_neurons = 30,
    parameter int data_width  = 16,
    parameter int addr_width  = (num_inputs  > 1) ? $clog2(num_inputs)  : 1,
    parameter int idx_width   = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              in_ren,
    output logic [addr_width-1:0]             in_raddr,
    input  logic [data_width-1:0]             in_rdata,
    output logic                              nrn_in_valid,
    output logic [data_width-1:0]             nrn_in,
    input  logic [num_neurons-1:0]            nrn_out_valid,
    input  logic [num_neurons*data_width-1:0] nrn_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [data_width-1:0]             out_data,
    output logic [idx_width-1:0]              out_idx,
    output logic                              out_last
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t                  state, state_next;
    logic                    busy_next, done_next, err_next;
    logic                    ren_next;
    logic [addr_width-1:0]   raddr_next;
    logic                    ov_next, ol_next;
    logic [data_width-1:0]   od_next;
    logic [idx_width-1:0]    oi_next;
    logic [idx_width-1:0]    idx_inc;
    logic                    cap_en;
    logic                    ren_d1;

    logic [data_width-1:0]   cap [num_neurons];

    assign idx_inc = out_idx + idx_width'(1);

    // Next-state and next-value decode for every registered output.
    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        err_next   = err;
        ren_next   = in_ren;
        raddr_next = in_raddr;
        ov_next    = out_valid;
        od_next    = out_data;
        oi_next    = out_idx;
        ol_next    = out_last;
        cap_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FEED;
                    busy_next  = 1'b1;
                    ren_next   = 1'b1;
                    raddr_next = '0;
                    err_next   = 1'b0;
                end
            end
            ST_FEED: begin
                if (in_raddr == addr_width'(num_inputs - 1)) begin
                    ren_next   = 1'b0;
                    raddr_next = '0;
                    state_next = ST_WAIT;
                end else begin
                    raddr_next = in_raddr + addr_width'(1);
                end
            end
            ST_WAIT: begin
                // The first valid from any neuron closes the wait; a partial
                // valid vector is flagged but the words are still taken.
                if (|nrn_out_valid) begin
                    cap_en     = 1'b1;
                    err_next   = err | ~(&nrn_out_valid);
                    state_next = ST_DRAIN;
                    ov_next    = 1'b1;
                    oi_next    = '0;
                    od_next    = nrn_out[data_width-1:0];
                    ol_next    = (num_neurons == 1);
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        ov_next    = 1'b0;
                        ol_next    = 1'b0;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        oi_next = idx_inc;
                        od_next = cap[idx_inc];
                        ol_next = (idx_inc == idx_width'(num_neurons - 1));
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers, plus the two-stage activation broadcast pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            in_ren       <= 1'b0;
            in_raddr     <= '0;
            ren_d1       <= 1'b0;
            nrn_in_valid <= 1'b0;
            nrn_in       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_last     <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= busy_next;
            done         <= done_next;
            err          <= err_next;
            in_ren       <= ren_next;
            in_raddr     <= raddr_next;
            ren_d1       <= in_ren;
            nrn_in_valid <= ren_d1;
            if (ren_d1) begin
                nrn_in <= in_rdata;
            end
            out_valid    <= ov_next;
            out_data     <= od_next;
            out_idx      <= oi_next;
            out_last     <= ol_next;
        end
    end

    // Capture array holds all neuron outputs for the drain; deliberately unreset.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int k = 0; k < num_neurons; k++) begin
                cap[k] <= nrn_out[k*data_width +: data_width];
            end
        end
    end

endmodule
